// File: rtl/signed_bcd_converter_pkg.sv
// Shared definitions for the signed binary-to-BCD converter: FSM states,
// digit-correction constants and an elaboration-time helper.
package bcd_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    SHIFT = 2'd2,
    DONE  = 2'd3
  } state_t;

  localparam int unsigned BCD_DIGIT_W = 4;
  localparam logic [BCD_DIGIT_W-1:0] ADJ_THRESHOLD = 4'd5;
  localparam logic [BCD_DIGIT_W-1:0] ADJ_ADD       = 4'd3;

  function automatic longint unsigned pow10(input int unsigned n);
    longint unsigned r;
    r = 1;
    for (int unsigned i = 0; i < n; i++) begin
      r = r * 10;
    end
    return r;
  endfunction

endpackage

// File: rtl/signed_bcd_converter_if.sv
// Request/result bundle between the value source and the BCD converter.
interface signed_bcd_converter_if #(
  parameter int unsigned WIDTH  = 8,
  parameter int unsigned DIGITS = 3
);
  logic [WIDTH-1:0]    in;
  logic                start;
  logic                busy;
  logic                done;
  logic                valid;
  logic                neg;
  logic [4*DIGITS-1:0] bcd;

  modport master (
    output in, start,
    input  busy, done, valid, neg, bcd
  );

  modport slave (
    input  in, start,
    output busy, done, valid, neg, bcd
  );
endinterface

// File: rtl/signed_bcd_converter_add3.sv
// Single-digit double-dabble correction: digits of 5 or more get +3 before the shift.
module bcd_add3
  import bcd_pkg::*;
(
  input  logic [BCD_DIGIT_W-1:0] d,
  output logic [BCD_DIGIT_W-1:0] q
);
  always_comb begin
    q = (d >= ADJ_THRESHOLD) ? d + ADJ_ADD : d;
  end
endmodule

// File: rtl/signed_bcd_converter.sv
// Sequential signed binary-to-BCD converter (double dabble, one bit per clock).
// Results are committed atomically so a display never sees partial digits.
module signed_bcd_converter
  import bcd_pkg::*;
#(
  parameter int unsigned WIDTH  = 8,
  parameter int unsigned DIGITS = 3,
  parameter bit          SIGNED = 1'b1,
  parameter bit          AUTO   = 1'b0
) (
  input logic                   clk,
  input logic                   rst,
  signed_bcd_converter_if.slave bus
);
  localparam int unsigned SW = BCD_DIGIT_W * DIGITS;
  localparam int unsigned CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  if (pow10(DIGITS) <= (64'd1 << WIDTH)) begin : g_digits_check
    $error("signed_bcd_converter: DIGITS too small for WIDTH");
  end

  state_t          state;
  logic            busy_q;
  logic            done_q;
  logic            valid_q;
  logic            neg_q;
  logic [SW-1:0]   bcd_q;
  logic [WIDTH-1:0] last_in;
  logic [WIDTH-1:0] mag;
  logic [SW-1:0]   scratch;
  logic [CW-1:0]   cnt;
  logic            sign;
  logic            pending;

  logic             in_neg;
  logic [WIDTH-1:0] in_mag;
  logic [SW-1:0]    adj;
  logic [SW-1:0]    scratch_nx;
  logic [WIDTH-1:0] mag_nx;
  logic             go;

  for (genvar g = 0; g < DIGITS; g++) begin : g_adj
    bcd_add3 u_add3 (
      .d (scratch[g*BCD_DIGIT_W +: BCD_DIGIT_W]),
      .q (adj[g*BCD_DIGIT_W +: BCD_DIGIT_W])
    );
  end

  // The largest magnitude is 2^(WIDTH-1), which still fits in WIDTH unsigned bits,
  // so the WIDTH-bit negation is exact (including the most negative input).
  always_comb begin
    in_neg = SIGNED && bus.in[WIDTH-1];
    in_mag = in_neg ? (~bus.in + WIDTH'(1)) : bus.in;
    {scratch_nx, mag_nx} = {adj, mag} << 1;
    go = AUTO ? ((bus.in != last_in) || pending || !valid_q) : bus.start;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state   <= IDLE;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      valid_q <= 1'b0;
      neg_q   <= 1'b0;
      bcd_q   <= '0;
      last_in <= '0;
      mag     <= '0;
      scratch <= '0;
      cnt     <= '0;
      sign    <= 1'b0;
      pending <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          done_q <= 1'b0;
          if (go) begin
            state  <= LOAD;
            busy_q <= 1'b1;
          end
        end
        LOAD: begin
          last_in <= bus.in;
          mag     <= in_mag;
          sign    <= in_neg;
          scratch <= '0;
          cnt     <= CW'(WIDTH - 1);
          state   <= SHIFT;
        end
        SHIFT: begin
          scratch <= scratch_nx;
          mag     <= mag_nx;
          if (AUTO && (bus.in != last_in)) begin
            pending <= 1'b1;
          end
          // Results are registered on the final shift so done and bcd appear together.
          if (cnt == '0) begin
            state   <= DONE;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            valid_q <= 1'b1;
            bcd_q   <= scratch_nx;
            neg_q   <= sign;
          end else begin
            cnt <= cnt - CW'(1);
          end
        end
        DONE: begin
          done_q  <= 1'b0;
          pending <= 1'b0;
          state   <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.busy  = busy_q;
  assign bus.done  = done_q;
  assign bus.valid = valid_q;
  assign bus.neg   = neg_q;
  assign bus.bcd   = bcd_q;

endmodule

// File: tb/tb_signed_bcd_converter.sv
// Directed bench: unsigned and signed converters share in/start; a third instance runs in AUTO mode.
module tb_signed_bcd_converter;
  logic       clk;
  logic       rst;
  logic [7:0] in_v;
  logic       start_v;
  logic [7:0] in_a;

  int total = 0;
  int bad   = 0;

  logic [11:0] prev_u, prev_s;
  logic        prev_nu, prev_ns;

  signed_bcd_converter_if #(.WIDTH(8), .DIGITS(3)) if_u ();
  signed_bcd_converter_if #(.WIDTH(8), .DIGITS(3)) if_s ();
  signed_bcd_converter_if #(.WIDTH(8), .DIGITS(3)) if_a ();

  assign if_u.in    = in_v;
  assign if_u.start = start_v;
  assign if_s.in    = in_v;
  assign if_s.start = start_v;
  assign if_a.in    = in_a;
  assign if_a.start = 1'b0;

  signed_bcd_converter #(.WIDTH(8), .DIGITS(3), .SIGNED(1'b0), .AUTO(1'b0)) dut_u (
    .clk (clk), .rst (rst), .bus (if_u.slave)
  );
  signed_bcd_converter #(.WIDTH(8), .DIGITS(3), .SIGNED(1'b1), .AUTO(1'b0)) dut_s (
    .clk (clk), .rst (rst), .bus (if_s.slave)
  );
  signed_bcd_converter #(.WIDTH(8), .DIGITS(3), .SIGNED(1'b0), .AUTO(1'b1)) dut_a (
    .clk (clk), .rst (rst), .bus (if_a.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Start pulse sampled at the end of cycle 0; samples are taken mid-cycle on negedge.
  task automatic conv(input logic [7:0] v,
                      input logic [11:0] eu, input logic enu,
                      input logic [11:0] es, input logic ens,
                      input bit poke4);
    in_v    = v;
    start_v = 1'b1;
    for (int k = 1; k <= 9; k++) begin
      @(negedge clk);
      start_v = (poke4 && k == 4) ? 1'b1 : 1'b0;
      chk("busy_u", 16'(if_u.busy), 16'(1));
      chk("done_u", 16'(if_u.done), 16'(0));
      chk("hold_bcd_u", 16'(if_u.bcd), 16'(prev_u));
      chk("hold_bcd_s", 16'(if_s.bcd), 16'(prev_s));
      chk("hold_neg_s", 16'(if_s.neg), 16'(prev_ns));
    end
    @(negedge clk);
    start_v = 1'b0;
    chk("done_u_c10", 16'(if_u.done), 16'(1));
    chk("done_s_c10", 16'(if_s.done), 16'(1));
    chk("busy_u_c10", 16'(if_u.busy), 16'(0));
    chk("valid_u", 16'(if_u.valid), 16'(1));
    chk("bcd_u", 16'(if_u.bcd), 16'(eu));
    chk("neg_u", 16'(if_u.neg), 16'(enu));
    chk("bcd_s", 16'(if_s.bcd), 16'(es));
    chk("neg_s", 16'(if_s.neg), 16'(ens));
    @(negedge clk);
    chk("done_u_c11", 16'(if_u.done), 16'(0));
    chk("done_s_c11", 16'(if_s.done), 16'(0));
    if (poke4) begin
      for (int k = 0; k < 3; k++) begin
        @(negedge clk);
        chk("poke_busy", 16'(if_u.busy), 16'(0));
        chk("poke_done", 16'(if_u.done), 16'(0));
      end
    end
    prev_u  = eu;
    prev_nu = enu;
    prev_s  = es;
    prev_ns = ens;
  endtask

  initial begin
    int dones;
    rst     = 1'b0;
    in_v    = 8'h00;
    start_v = 1'b0;
    in_a    = 8'h00;
    prev_u  = '0;
    prev_s  = '0;
    prev_nu = 1'b0;
    prev_ns = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("rst_busy", 16'(if_u.busy), 16'(0));
    chk("rst_done", 16'(if_u.done), 16'(0));
    chk("rst_valid", 16'(if_u.valid), 16'(0));
    chk("rst_neg", 16'(if_s.neg), 16'(0));
    chk("rst_bcd", 16'(if_s.bcd), 16'(0));
    chk("rst_valid_a", 16'(if_a.valid), 16'(0));

    // AUTO instance converts 0 right after reset; in changes during that conversion.
    rst = 1'b1;
    dones = 0;
    for (int k = 1; k <= 45; k++) begin
      @(negedge clk);
      if (k == 3) in_a = 8'h0C;
      if (k == 1) chk("auto_busy_c1", 16'(if_a.busy), 16'(1));
      if (k == 10) begin
        chk("auto_done_c10", 16'(if_a.done), 16'(1));
        chk("auto_bcd_zero", 16'(if_a.bcd), 16'(0));
        chk("auto_valid", 16'(if_a.valid), 16'(1));
      end
      if (k == 15) chk("auto_hold", 16'(if_a.bcd), 16'(0));
      if (k == 21) chk("auto_done_c21", 16'(if_a.done), 16'(1));
      if (k > 10 && if_a.done) dones++;
    end
    total++;
    assert (dones == 1) else begin
      bad++;
      $error("FAIL auto_followups observed=%0d expected=1", dones);
    end
    chk("auto_bcd_0c", 16'(if_a.bcd), 16'h012);
    chk("auto_idle", 16'(if_a.busy), 16'(0));
    chk("manual_still_invalid", 16'(if_u.valid), 16'(0));

    conv(8'h2A, 12'h042, 1'b0, 12'h042, 1'b0, 1'b0);
    conv(8'h80, 12'h128, 1'b0, 12'h128, 1'b1, 1'b0);
    conv(8'hFF, 12'h255, 1'b0, 12'h001, 1'b1, 1'b0);
    conv(8'h7F, 12'h127, 1'b0, 12'h127, 1'b0, 1'b0);
    conv(8'h00, 12'h000, 1'b0, 12'h000, 1'b0, 1'b0);
    conv(8'h05, 12'h005, 1'b0, 12'h005, 1'b0, 1'b0);
    conv(8'h63, 12'h099, 1'b0, 12'h099, 1'b0, 1'b1);

    // Asynchronous reset in the middle of a conversion.
    in_v    = 8'hC8;
    start_v = 1'b1;
    for (int k = 1; k <= 5; k++) begin
      @(negedge clk);
      start_v = 1'b0;
    end
    chk("pre_rst_busy", 16'(if_s.busy), 16'(1));
    rst = 1'b0;
    #1;
    chk("arst_busy", 16'(if_s.busy), 16'(0));
    chk("arst_done", 16'(if_s.done), 16'(0));
    chk("arst_valid", 16'(if_s.valid), 16'(0));
    chk("arst_neg", 16'(if_s.neg), 16'(0));
    chk("arst_bcd", 16'(if_s.bcd), 16'(0));
    @(negedge clk);
    rst = 1'b1;
    prev_u  = '0;
    prev_s  = '0;
    prev_nu = 1'b0;
    prev_ns = 1'b0;
    conv(8'hC8, 12'h200, 1'b0, 12'h056, 1'b1, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/signed_bcd_converter.md
Name: signed_bcd_converter

Overview:
Sequential binary-to-BCD converter that sits downstream of the add_sub accumulator. It takes the 8-bit sum or operand and produces a sign flag plus three BCD digits for decimal display on the HEX outputs. It uses iterative shift-and-add-3 (double dabble), one bit per clock. Results are held stable between conversions so the display never shows partial values.

Parameters:
WIDTH, 8, binary input width
DIGITS, 3, number of BCD output digits; elaboration error unless 10^DIGITS > 2^WIDTH
SIGNED, 1, 1 = input is two's complement, 0 = unsigned
AUTO, 0, 1 = start a conversion automatically whenever in differs from the last converted value

Ports:
clk  input  1  system clock
rst  input  1  reset, asynchronous, active-low
in  input  WIDTH  binary value to convert
start  input  1  conversion request, sampled only in IDLE (ignored when AUTO=1)
busy  output  1  high from LOAD through SHIFT
done  output  1  one-cycle pulse when new results are committed
valid  output  1  high once any conversion has completed since reset
neg  output  1  sign of the last converted value
bcd  output  4*DIGITS  BCD digits, most significant digit in the top nibble

Behaviour:
- Reset (rst=0, async): state=IDLE; busy=0, done=0, valid=0, neg=0, bcd=0; working registers, bit counter and pending flag cleared. Reset mid-conversion abandons the conversion and commits nothing.
- FSM states: IDLE, LOAD, SHIFT, DONE.
- IDLE -> LOAD when:
  - AUTO=0 and start=1; or
  - AUTO=1 and (in != last_in or pending=1 or valid=0).
- LOAD (1 cycle):
  - latch in into last_in.
  - compute magnitude in WIDTH+1 bits: if SIGNED and in[MSB]=1, mag = -in; else mag = in. -128 gives mag=128.
  - latch the sign; clear the BCD scratch; counter = WIDTH-1.
- SHIFT (WIDTH cycles):
  - each cycle, every scratch digit >= 5 gets +3, then {scratch, mag} shifts left by 1.
  - counter decrements; leave for DONE when counter = 0.
- DONE (1 cycle): bcd <= scratch, neg <= latched sign, done=1, valid=1, pending cleared -> IDLE.
- Latency: start sampled in cycle 0, done high in cycle WIDTH+2 (10 for WIDTH=8). Minimum start-to-start spacing is WIDTH+3 cycles.
- bcd and neg change only in DONE and are held otherwise, including while busy.
- start while busy (AUTO=0): ignored, no queuing.
- in changes while busy (AUTO=1): pending=1; a new conversion starts in the IDLE cycle after DONE. Multiple changes collapse to one pending request.
- neg=1 only for a strictly negative input. Zero always gives neg=0, bcd=0.
- Unused upper digits are 0 (no blanking; blanking is the display stage's job).

Decomposition:
- Shared package bcd_pkg:
  - state encoding: IDLE=2'd0, LOAD=2'd1, SHIFT=2'd2, DONE=2'd3.
  - BCD_DIGIT_W=4; ADJ_THRESHOLD=5; ADJ_ADD=3.
- Sub-module bcd_add3: combinational 4-bit digit correction (d>=5 ? d+3 : d). Instantiated DIGITS times by a generate loop in the SHIFT datapath.

Test Plan:
- AUTO=0, SIGNED=0, in=8'h2A, 1-cycle start -> busy high cycles 1-9, done pulse at cycle 10, bcd=12'h042, neg=0, valid=1.
- SIGNED=1: in=8'h80 -> bcd=12'h128, neg=1. in=8'hFF -> bcd=12'h001, neg=1. in=8'h7F -> bcd=12'h127, neg=0. SIGNED=0, in=8'hFF -> bcd=12'h255, neg=0.
- Held output and ignored start:
  - convert 8'h05, then convert 8'h63.
  - during the 8'h63 conversion, bcd must stay 12'h005 until done; final result 12'h099.
  - a start pulse at cycle 4 of that conversion produces no extra done pulse.
- AUTO=1:
  - after reset with in=0 -> one conversion, bcd=0, valid=1.
  - change in to 8'h0C at cycle 3 of a conversion -> exactly one follow-up conversion; final bcd=12'h012; no further done while in is stable.
- Reset mid-conversion:
  - in=8'hC8, assert rst=0 at cycle 5 -> busy, done, valid, neg and bcd all 0 immediately (asynchronous).
  - after release plus start -> bcd=12'h056, neg=1 (SIGNED=1), done at cycle 10.
